axil_master: RTL and testbench

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_pkg.sv | 12 +
 rtl/axil_if.sv | 45 ++++
 rtl/axil_master.sv | 166 ++++++++++++++++
 tb/tb_axil_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI-Lite bus widths for the command-to-AXI-Lite
//               master and its bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;
    parameter int AXI_ADDR_WIDTH = 32;
    parameter int AXI_DATA_WIDTH = 32;
endpackage
`default_nettype wire

// File: rtl/axil_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_if
// Description : AXI-Lite bus bundle (AW, W, B, AR, R channels).
//               m_axil : master view, s_axil : slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_if;
    logic                                     awvalid;
    logic                                     awready;
    logic [axil_pkg::AXI_ADDR_WIDTH-1:0]      awaddr;
    logic [2:0]                               awprot;
    logic                                     wvalid;
    logic                                     wready;
    logic [axil_pkg::AXI_DATA_WIDTH-1:0]      wdata;
    logic [axil_pkg::AXI_DATA_WIDTH/8-1:0]    wstrb;
    logic                                     bvalid;
    logic                                     bready;
    logic [1:0]                               bresp;
    logic                                     arvalid;
    logic                                     arready;
    logic [axil_pkg::AXI_ADDR_WIDTH-1:0]      araddr;
    logic [2:0]                               arprot;
    logic                                     rvalid;
    logic                                     rready;
    logic [axil_pkg::AXI_DATA_WIDTH-1:0]      rdata;
    logic [1:0]                               rresp;

    modport m_axil (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input  bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp, output rready
    );

    modport s_axil (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_master
// Description : Single-outstanding AXI-Lite master. Accepts one read or
//               write command, runs it on the AXI-Lite bus, returns the
//               completion on the rsp channel and keeps saturating counts.
// Ports       : aclk, aresetn          - clock / async active-low reset
//               cmd_*                  - command request (valid/ready)
//               rsp_*                  - completion (valid/ready)
//               wr_count/rd_count/err_count - 16-bit saturating statistics
//               m_axil                 - AXI-Lite master port
// Revision    : 1.0 - initial release
// ============================================================================
module axil_master
    import axil_pkg::*;
(
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [15:0]                   wr_count,
    output logic [15:0]                   rd_count,
    output logic [15:0]                   err_count,
    axil_if.m_axil                        m_axil
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    state_t                        state_q;
    logic                          write_q;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic                          arvalid_q;
    logic [AXI_DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                    rsp_resp_q;
    logic [15:0]                   wr_cnt_q;
    logic [15:0]                   rd_cnt_q;
    logic [15:0]                   err_cnt_q;

    // A channel counts as done once its valid has already dropped or its
    // handshake is completing this cycle.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || m_axil.awready;
    assign w_done  = !wvalid_q  || m_axil.wready;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            wr_cnt_q    <= 16'd0;
            rd_cnt_q    <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        write_q <= cmd_write;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W retire independently; either may finish first.
                    if (m_axil.awready) awvalid_q <= 1'b0;
                    if (m_axil.wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (m_axil.bvalid) begin
                        rsp_resp_q  <= m_axil.bresp;
                        rsp_rdata_q <= '0;
                        state_q     <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (m_axil.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axil.rvalid) begin
                        rsp_rdata_q <= m_axil.rdata;
                        rsp_resp_q  <= m_axil.rresp;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        if (write_q) wr_cnt_q <= sat_inc(wr_cnt_q);
                        else         rd_cnt_q <= sat_inc(rd_cnt_q);
                        if (rsp_resp_q != 2'b00) err_cnt_q <= sat_inc(err_cnt_q);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake-side controls decode the registered state only.
    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == RSP);
    assign m_axil.bready  = (state_q == WR_RESP);
    assign m_axil.rready  = (state_q == RD_DATA);

    assign rsp_write      = write_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign wr_count       = wr_cnt_q;
    assign rd_count       = rd_cnt_q;
    assign err_count      = err_cnt_q;

    assign m_axil.awvalid = awvalid_q;
    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_axil_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axil_master
// Description : Self-checking bench for axil_master: programmable-wait
//               AXI-Lite slave, latency/counter reference model, directed
//               corner cases plus randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_master;
    import axil_pkg::*;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [15:0]   wr_count, rd_count, err_count;

    axil_if bus ();

    axil_master dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .wr_count  (wr_count),
        .rd_count  (rd_count),
        .err_count (err_count),
        .m_axil    (bus)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Step to just after the falling edge (slave model has already acted).
    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    // ---------------- slave model ----------------
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_beats, w_beats, b_beats, ar_beats, r_beats;
    int proto_err;
    logic [1:0]    bresp_next, rresp_next;
    logic [DW-1:0] rdata_next;
    logic [AW-1:0] aw_seen, ar_seen, aw_hold, ar_hold;
    logic [DW-1:0] w_seen, w_hold_d;
    logic [SW-1:0] strb_seen, w_hold_s;
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit aw_pend, w_pend, ar_pend;

    initial begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
                bus.bvalid = 1'b0; bus.rvalid = 1'b0;
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                // handshakes completed at the rising edge just past
                if (aw_fire) aw_beats++;
                if (w_fire)  w_beats++;
                if (b_fire)  begin b_beats++; bus.bvalid = 1'b0; end
                if (ar_fire) ar_beats++;
                if (r_fire)  begin r_beats++; bus.rvalid = 1'b0; end
                // a pending valid must hold with unchanged payload
                if (aw_pend && (!bus.awvalid || bus.awaddr !== aw_hold)) proto_err++;
                if (w_pend && (!bus.wvalid || bus.wdata !== w_hold_d || bus.wstrb !== w_hold_s)) proto_err++;
                if (ar_pend && (!bus.arvalid || bus.araddr !== ar_hold)) proto_err++;
                // ready decisions after the programmed number of wait cycles
                if (bus.awvalid) begin
                    if (aw_cnt >= aw_wait) bus.awready = 1'b1;
                    else begin bus.awready = 1'b0; aw_cnt++; end
                end else bus.awready = 1'b0;
                if (bus.wvalid) begin
                    if (w_cnt >= w_wait) bus.wready = 1'b1;
                    else begin bus.wready = 1'b0; w_cnt++; end
                end else bus.wready = 1'b0;
                if (bus.arvalid) begin
                    if (ar_cnt >= ar_wait) bus.arready = 1'b1;
                    else begin bus.arready = 1'b0; ar_cnt++; end
                end else bus.arready = 1'b0;
                if (aw_beats > 0 && w_beats > 0 && b_beats == 0 && !bus.bvalid) begin
                    if (b_cnt >= b_wait) begin bus.bvalid = 1'b1; bus.bresp = bresp_next; end
                    else b_cnt++;
                end
                if (ar_beats > 0 && r_beats == 0 && !bus.rvalid) begin
                    if (r_cnt >= r_wait) begin
                        bus.rvalid = 1'b1; bus.rdata = rdata_next; bus.rresp = rresp_next;
                    end else r_cnt++;
                end
                // handshakes that will complete at the coming rising edge
                aw_fire = bus.awvalid && bus.awready;
                if (aw_fire) aw_seen = bus.awaddr;
                w_fire = bus.wvalid && bus.wready;
                if (w_fire) begin w_seen = bus.wdata; strb_seen = bus.wstrb; end
                ar_fire = bus.arvalid && bus.arready;
                if (ar_fire) ar_seen = bus.araddr;
                b_fire = bus.bvalid && bus.bready;
                r_fire = bus.rvalid && bus.rready;
                aw_pend = bus.awvalid && !bus.awready; aw_hold = bus.awaddr;
                w_pend  = bus.wvalid && !bus.wready;   w_hold_d = bus.wdata; w_hold_s = bus.wstrb;
                ar_pend = bus.arvalid && !bus.arready; ar_hold = bus.araddr;
            end
        end
    end

    // ---------------- reference counters ----------------
    logic [15:0] m_wr = 16'd0, m_rd = 16'd0, m_err = 16'd0;

    task automatic arm_slave(input int aww, ww, bw, arw, rw,
                             input logic [1:0] resp, input logic [DW-1:0] rd);
        aw_wait = aww; w_wait = ww; b_wait = bw; ar_wait = arw; r_wait = rw;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0;
        proto_err = 0;
        bresp_next = resp; rresp_next = resp; rdata_next = rd;
    endtask

    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int aww, ww, bw, arw, rw,
                           input logic [1:0] resp, input logic [DW-1:0] rd, input int hold);
        int cyc;
        int exp_lat;
        bit unstable;
        logic [DW-1:0] h_rdata;
        logic [1:0]    h_resp;
        logic          h_write;
        arm_slave(aww, ww, bw, arw, rw, resp, rd);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cyc = 0;
        while (!cmd_ready && cyc < 50) begin tick(); cyc++; end
        chk("cmd_accept", cmd_ready, 1);
        tick();
        // scramble the command bus so later checks prove the values were latched
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
        exp_lat = wr ? 3 + ((aww > ww) ? aww : ww) + bw : 3 + arw + rw;
        chk("latency", cyc, exp_lat);
        chk("rsp_write", rsp_write, wr);
        chk("rsp_rdata", rsp_rdata, wr ? '0 : rd);
        chk("rsp_resp", rsp_resp, resp);
        chk("beats", {8'(aw_beats), 8'(w_beats), 8'(b_beats), 8'(ar_beats), 8'(r_beats)},
            wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
        if (wr) begin
            chk("awaddr", aw_seen, a);
            chk("wdata", w_seen, d);
            chk("wstrb", strb_seen, s);
        end else begin
            chk("araddr", ar_seen, a);
        end
        // hold off the response while a competing command waits
        h_rdata = rsp_rdata; h_resp = rsp_resp; h_write = rsp_write;
        unstable = 0;
        cmd_valid = 1'b1; cmd_write = 1'($urandom);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!rsp_valid || cmd_ready || rsp_rdata !== h_rdata ||
                rsp_resp !== h_resp || rsp_write !== h_write) unstable = 1;
        end
        chk("rsp_hold_stable", unstable, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("post_rsp_idle", {rsp_valid, cmd_ready}, 2'b01);
        if (wr) m_wr = (m_wr == 16'hFFFF) ? m_wr : m_wr + 16'd1;
        else    m_rd = (m_rd == 16'hFFFF) ? m_rd : m_rd + 16'd1;
        if (resp != 2'b00) m_err = (m_err == 16'hFFFF) ? m_err : m_err + 16'd1;
        chk("counters", {wr_count, rd_count, err_count}, {m_wr, m_rd, m_err});
        chk("protocol", proto_err, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valids"}, {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 6'b0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_counters"}, {wr_count, rd_count, err_count}, 48'd0);
        chk({tag, "_data"}, |{rsp_rdata, rsp_resp, rsp_write, bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 0);
    endtask

    initial begin
        #500us;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit wr;
        int cyc;
        // reset state
        aresetn = 1'b0;
        tick(); tick();
        check_reset_values("reset");
        aresetn = 1'b1;
        tick();
        chk("ready_after_release", cmd_ready, 1);

        // zero-wait write
        run_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, '0, 0);
        // W accepted four cycles before AW, one B wait
        run_txn(1, 32'h0000_0020, 32'hCAFE_F00D, 4'h5, 4, 0, 1, 0, 0, 2'b00, '0, 1);
        // read with SLVERR after five data waits
        run_txn(0, 32'h0000_0004, '0, '0, 0, 0, 0, 0, 5, 2'b10, 32'h1234_5678, 0);
        // zero-wait read
        run_txn(0, 32'h0000_0100, '0, '0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_5A5A, 0);
        // response held off for ten cycles with a command pending
        run_txn(1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3, 0, 2, 0, 0, 0, 2'b11, '0, 10);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            run_txn(wr, $urandom & 32'hFFFF_FFFC, $urandom, SW'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3));
        end

        // reset pulse while waiting for the write response
        arm_slave(0, 0, 50, 0, 0, 2'b00, '0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!bus.bready && cyc < 20) begin tick(); cyc++; end
        chk("reached_wr_resp", bus.bready, 1);
        #2 aresetn = 1'b0;
        #1;
        check_reset_values("midreset");
        m_wr = 16'd0; m_rd = 16'd0; m_err = 16'd0;
        tick(); tick();
        chk("midreset_no_rsp", rsp_valid, 0);
        aresetn = 1'b1;
        tick();
        chk("ready_after_midreset", {cmd_ready, rsp_valid}, 2'b10);
        run_txn(0, 32'h0000_0008, '0, '0, 1, 0, 0, 1, 1, 2'b00, 32'h7777_8888, 0);

        // saturation of the write counter
        force dut.wr_cnt_q = 16'hFFFF;
        tick();
        release dut.wr_cnt_q;
        tick();
        m_wr = 16'hFFFF;
        chk("wr_count_forced", wr_count, 16'hFFFF);
        run_txn(1, 32'h0000_0050, 32'h0123_4567, 4'hC, 0, 0, 0, 0, 0, 2'b00, '0, 0);
        run_txn(1, 32'h0000_0054, 32'h89AB_CDEF, 4'h1, 1, 2, 0, 0, 0, 2'b01, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
